// File: rtl/rect_fill_engine.sv
// Rectangle rasterizer: takes one clipped fill command over valid/ready and
// streams row-major pixel writes to the vga_adapter write port.
module rect_fill_engine #(
  parameter int nX          = 10,
  parameter int nY          = 9,
  parameter int COLOR_DEPTH = 9,
  parameter int X_MAX       = 640,
  parameter int Y_MAX       = 480
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [nX-1:0]          cmd_x,
  input  logic [nY-1:0]          cmd_y,
  input  logic [nX-1:0]          cmd_w,
  input  logic [nY-1:0]          cmd_h,
  input  logic [COLOR_DEPTH-1:0] cmd_color,
  output logic [nX-1:0]          pix_x,
  output logic [nY-1:0]          pix_y,
  output logic [COLOR_DEPTH-1:0] pix_color,
  output logic                   pix_write,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

  localparam logic [nX:0] X_LIM = (nX+1)'(X_MAX);
  localparam logic [nY:0] Y_LIM = (nY+1)'(Y_MAX);

  state_t                 state;
  logic [nX-1:0]          x_q;
  logic [nX-1:0]          w_q;
  logic [nY-1:0]          y_q;
  logic [nY-1:0]          h_q;
  logic [COLOR_DEPTH-1:0] color_q;
  logic [nX:0]            x_last;
  logic [nY:0]            y_last;
  logic                   empty;
  logic                   col_last;
  logic                   row_last;

  // Sums are formed one bit wider than the operands so they cannot wrap.
  function automatic logic [nX:0] sat_x(input logic [nX-1:0] org, input logic [nX-1:0] len);
    logic [nX:0] s;
    s = {1'b0, org} + {1'b0, len};
    return (s > X_LIM) ? X_LIM : s;
  endfunction

  function automatic logic [nY:0] sat_y(input logic [nY-1:0] org, input logic [nY-1:0] len);
    logic [nY:0] s;
    s = {1'b0, org} + {1'b0, len};
    return (s > Y_LIM) ? Y_LIM : s;
  endfunction

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  assign empty    = (w_q == '0) || (h_q == '0) ||
                    ({1'b0, x_q} >= X_LIM) || ({1'b0, y_q} >= Y_LIM);
  assign col_last = ({1'b0, pix_x} == x_last);
  assign row_last = ({1'b0, pix_y} == y_last);

  // Command latch and clipped last coordinates; pure data, no reset needed.
  always_ff @(posedge Clock) begin
    if (state == IDLE && cmd_valid) begin
      x_q     <= cmd_x;
      y_q     <= cmd_y;
      w_q     <= cmd_w;
      h_q     <= cmd_h;
      color_q <= cmd_color;
    end
    if (state == SETUP) begin
      x_last <= sat_x(x_q, w_q) - (nX+1)'(1);
      y_last <= sat_y(y_q, h_q) - (nY+1)'(1);
    end
  end

  // The pixel output registers double as the column/row counters.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= IDLE;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_color <= '0;
      pix_write <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) state <= SETUP;
        end
        SETUP: begin
          if (empty) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            pix_x     <= x_q;
            pix_y     <= y_q;
            pix_color <= color_q;
            pix_write <= 1'b1;
            state     <= DRAW;
          end
        end
        DRAW: begin
          if (col_last && row_last) begin
            pix_write <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else if (col_last) begin
            pix_x <= x_q;
            pix_y <= pix_y + nY'(1);
          end else begin
            pix_x <= pix_x + nX'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine against a loop-based pixel model.
module tb_rect_fill_engine;
  localparam int nX = 10, nY = 9, CD = 9, XM = 640, YM = 480;

  logic          Clock = 1'b0;
  logic          Resetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [nX-1:0] cmd_x = '0, cmd_w = '0;
  logic [nY-1:0] cmd_y = '0, cmd_h = '0;
  logic [CD-1:0] cmd_color = '0;
  logic [nX-1:0] pix_x;
  logic [nY-1:0] pix_y;
  logic [CD-1:0] pix_color;
  logic          pix_write, busy, done;

  int checks = 0, failures = 0;
  int cyc = 0;

  typedef struct {int x; int y; int c; int t;} pix_t;
  pix_t wr_q[$];
  pix_t exp_q[$];
  int   hs_q[$];
  int   done_q[$];

  rect_fill_engine #(.nX(nX), .nY(nY), .COLOR_DEPTH(CD), .X_MAX(XM), .Y_MAX(YM)) dut (
    .Clock(Clock), .Resetn(Resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .pix_write(pix_write),
    .busy(busy), .done(done)
  );

  always #10 Clock = ~Clock;
  always @(posedge Clock) cyc = cyc + 1;

  // Observation at the falling edge; a handshake seen here completes on the next rising edge.
  always @(negedge Clock) begin
    if (Resetn && cmd_valid && cmd_ready) hs_q.push_back(cyc);
    if (pix_write) wr_q.push_back('{int'(pix_x), int'(pix_y), int'(pix_color), cyc});
    if (done) done_q.push_back(cyc);
  end

  // Reference: every on-screen pixel of the rectangle, row-major, one per cycle from t0.
  task automatic model_rect(int x, int y, int w, int h, int c, int t0);
    int k = 0;
    for (int r = y; r < y + h && r < YM; r++)
      for (int cc = x; cc < x + w && cc < XM; cc++) begin
        exp_q.push_back('{cc, r, c, t0 + k});
        k++;
      end
  endtask

  task automatic scramble();
    cmd_x = nX'($urandom); cmd_y = nY'($urandom); cmd_w = nX'($urandom);
    cmd_h = nY'($urandom); cmd_color = CD'($urandom);
  endtask

  task automatic load(int x, int y, int w, int h, int c);
    cmd_x = nX'(x); cmd_y = nY'(y); cmd_w = nX'(w); cmd_h = nY'(h); cmd_color = CD'(c);
  endtask

  task automatic send_cmd(int x, int y, int w, int h, int c);
    int n = 0;
    @(posedge Clock); #1;
    load(x, y, w, h, c);
    cmd_valid = 1'b1;
    @(negedge Clock);
    while (!cmd_ready && n < 50) begin @(negedge Clock); n++; end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL send_cmd: cmd_ready stayed %0b for 50 cycles, required 1", cmd_ready);
    end
    @(posedge Clock); #1;
    cmd_valid = 1'b0;
    scramble();
  endtask

  task automatic wait_done(int budget, output bit to, output bit rd0, output bit rd1);
    int n = 0;
    to = 1'b0;
    @(negedge Clock);
    while (!done && n < budget) begin @(negedge Clock); n++; end
    if (n >= budget) to = 1'b1;
    rd0 = cmd_ready;
    @(negedge Clock);
    rd1 = cmd_ready;
  endtask

  task automatic do_rect(string name, int x, int y, int w, int h, int c);
    bit to, rd0, rd1;
    int hs, n, bad;
    wr_q.delete(); exp_q.delete(); hs_q.delete(); done_q.delete();
    send_cmd(x, y, w, h, c);
    wait_done(w * h + 20, to, rd0, rd1);
    hs = (hs_q.size() > 0) ? hs_q[0] : -1000;
    model_rect(x, y, w, h, c, hs + 2);
    n = exp_q.size();
    checks++;
    if (to) begin
      failures++;
      $display("FAIL %s timeout: done not seen, writes=%0d required=%0d", name, wr_q.size(), n);
    end
    checks++;
    if (wr_q.size() != n) begin
      failures++;
      $display("FAIL %s count: writes=%0d required=%0d", name, wr_q.size(), n);
    end
    if (n > 0) begin
      bad = -1;
      for (int i = 0; i < n && i < wr_q.size(); i++)
        if (bad < 0 && wr_q[i] != exp_q[i]) bad = i;
      checks++;
      if (bad >= 0) begin
        failures++;
        $display("FAIL %s pixel[%0d]: got (%0d,%0d) c=%0h t=%0d required (%0d,%0d) c=%0h t=%0d",
                 name, bad, wr_q[bad].x, wr_q[bad].y, wr_q[bad].c, wr_q[bad].t,
                 exp_q[bad].x, exp_q[bad].y, exp_q[bad].c, exp_q[bad].t);
      end
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] != hs + 2 + n) begin
      failures++;
      $display("FAIL %s done: pulses=%0d first_t=%0d required 1 pulse at t=%0d", name,
               done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, hs + 2 + n);
    end
    checks++;
    if (rd0 !== 1'b0 || rd1 !== 1'b1) begin
      failures++;
      $display("FAIL %s ready: at_done=%0b after=%0b required 0 then 1", name, rd0, rd1);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge Clock);
    #1;
    checks++;
    if ({cmd_ready, busy, done, pix_write} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_ctrl: ready/busy/done/write=%b required 1000",
               {cmd_ready, busy, done, pix_write});
    end
    checks++;
    if (pix_x !== '0 || pix_y !== '0 || pix_color !== '0) begin
      failures++;
      $display("FAIL reset_pix: x=%0d y=%0d c=%0h required 0", pix_x, pix_y, pix_color);
    end
    @(negedge Clock); Resetn = 1'b1;
    repeat (2) @(negedge Clock);
    checks++;
    if ({cmd_ready, busy, done, pix_write} !== 4'b1000) begin
      failures++;
      $display("FAIL idle_after_reset: ready/busy/done/write=%b required 1000",
               {cmd_ready, busy, done, pix_write});
    end
  endtask

  task automatic test_basic();
    do_rect("basic", 10, 20, 3, 2, 9'h1FF);
    checks++;
    if (pix_x !== 10'd12 || pix_y !== 9'd21 || pix_write !== 1'b0) begin
      failures++;
      $display("FAIL basic_hold: x=%0d y=%0d w=%0b required 12 21 0", pix_x, pix_y, pix_write);
    end
  endtask

  task automatic test_clip();
    do_rect("clip", 638, 478, 5, 5, 9'h0A5);
    do_rect("clip_wide", 600, 10, 1023, 2, 9'h033);
  endtask

  task automatic test_empty();
    do_rect("empty_w", 5, 5, 0, 4, 9'h001);
    do_rect("empty_h", 5, 5, 4, 0, 9'h002);
    do_rect("empty_x", 700, 5, 4, 4, 9'h003);
    do_rect("empty_y", 5, 500, 4, 4, 9'h004);
  endtask

  task automatic test_back_to_back();
    int n = 0, bad = -1;
    wr_q.delete(); exp_q.delete(); hs_q.delete(); done_q.delete();
    @(posedge Clock); #1;
    load(30, 40, 2, 1, 9'h111);
    cmd_valid = 1'b1;
    while (hs_q.size() < 1 && n < 50) begin @(posedge Clock); n++; end
    #1; load(50, 60, 1, 2, 9'h122);
    while (hs_q.size() < 2 && n < 100) begin @(posedge Clock); n++; end
    #1; cmd_valid = 1'b0;
    scramble();
    while (done_q.size() < 2 && n < 150) begin @(negedge Clock); n++; end
    @(negedge Clock);
    checks++;
    if (hs_q.size() != 2 || hs_q[1] != hs_q[0] + 5) begin
      failures++;
      $display("FAIL b2b_handshake: count=%0d gap=%0d required 2 with gap 5", hs_q.size(),
               (hs_q.size() == 2) ? hs_q[1] - hs_q[0] : -1);
    end
    if (hs_q.size() == 2) begin
      model_rect(30, 40, 2, 1, 9'h111, hs_q[0] + 2);
      model_rect(50, 60, 1, 2, 9'h122, hs_q[1] + 2);
    end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      if (bad < 0 && wr_q[i] != exp_q[i]) bad = i;
    checks++;
    if (wr_q.size() != 4 || exp_q.size() != 4 || bad >= 0) begin
      failures++;
      $display("FAIL b2b_pixels: writes=%0d first_bad=%0d required 4 matching", wr_q.size(), bad);
    end
    checks++;
    if (done_q.size() != 2 || hs_q.size() != 2 ||
        done_q[0] != hs_q[0] + 4 || done_q[1] != hs_q[1] + 4) begin
      failures++;
      $display("FAIL b2b_done: pulses=%0d required 2 at handshake+4", done_q.size());
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    wr_q.delete(); done_q.delete();
    send_cmd(100, 100, 10, 10, 9'h155);
    done_q.delete();
    while (wr_q.size() < 4 && n < 30) begin @(negedge Clock); #1; n++; end
    checks++;
    if (pix_write !== 1'b1 || pix_x !== 10'd103) begin
      failures++;
      $display("FAIL arst_pre: write=%0b x=%0d required 1 103", pix_write, pix_x);
    end
    Resetn = 1'b0;
    #2;
    checks++;
    if (pix_write !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || pix_x !== '0) begin
      failures++;
      $display("FAIL arst_immediate: write=%0b busy=%0b ready=%0b x=%0d required 0 0 1 0",
               pix_write, busy, cmd_ready, pix_x);
    end
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    repeat (3) @(negedge Clock);
    checks++;
    if (done_q.size() != 0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL arst_after: done_pulses=%0d ready=%0b required 0 1", done_q.size(), cmd_ready);
    end
    do_rect("arst_1x1", 7, 9, 1, 1, 9'h0F0);
  endtask

  task automatic test_random();
    int x, y, w, h;
    for (int i = 0; i < 24; i++) begin
      x = (i % 4 == 0) ? $urandom_range(630, 700) : $urandom_range(0, 639);
      y = (i % 4 == 1) ? $urandom_range(470, 511) : $urandom_range(0, 479);
      w = $urandom_range(0, 14);
      h = $urandom_range(0, 6);
      do_rect($sformatf("rand%0d", i), x, y, w, h, $urandom_range(0, 511));
    end
  endtask

  task automatic test_row_wrap();
    do_rect("row_wrap", 0, 465, 640, 20, 9'h0C3);
    checks++;
    if (wr_q.size() != 9600 || wr_q[wr_q.size()-1].x != 639 || wr_q[wr_q.size()-1].y != 479 ||
        wr_q[640].x != 0 || wr_q[640].y != 466) begin
      failures++;
      $display("FAIL row_wrap_ends: writes=%0d required 9600 ending (639,479)", wr_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip();
    test_empty();
    test_back_to_back();
    test_async_reset();
    test_random();
    test_row_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
